// File: rtl/dac_pkg.sv
// Shared definitions for the AD5313R DAC control path: frame layout,
// command codes, arbiter state encoding and a width helper.
package dac_pkg;

  localparam int FRAME_WIDTH = 24;

  localparam logic [3:0] WR_INPUT  = 4'h1;
  localparam logic [3:0] UPDATE    = 4'h2;
  localparam logic [3:0] WR_UPDATE = 4'h3;
  localparam logic [3:0] RESET     = 4'h6;
  localparam logic [3:0] READBACK  = 4'h9;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    GAP
  } arb_state_t;

  // Never returns less than 1 so single-entry indices still get a bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first set bit of valid at or
// above ptr, wrapping modulo NUM_REQ.
module rr_pick import dac_pkg::*; #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   index
);

  function automatic int wrap(input int v);
    return (v >= NUM_REQ) ? v - NUM_REQ : v;
  endfunction

  // Scan from the farthest offset inward so the hit closest to ptr is kept last.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (valid[wrap(int'(ptr) + k)]) begin
        found = 1'b1;
        index = IDX_W'(wrap(int'(ptr) + k));
      end
    end
  end

endmodule

// File: rtl/dac_frame_arbiter.sv
// Round-robin arbiter/sequencer sharing one AD5313R serial shifter between
// several frame requesters, with completion watchdog and inter-frame gap.
module dac_frame_arbiter import dac_pkg::*; #(
  parameter int NUM_REQ         = 3,
  parameter int FRAME_WIDTH     = dac_pkg::FRAME_WIDTH,
  parameter int WATCH_DOG_WIDTH = 12,
  parameter int GAP_CYCLES      = 4
) (
  input  logic                           sys_clk,
  input  logic                           sys_rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*FRAME_WIDTH-1:0] req_frame,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             req_done,
  output logic                           shf_valid,
  output logic [FRAME_WIDTH-1:0]         shf_frame,
  input  logic                           shf_ready,
  input  logic                           shf_done,
  output logic                           shf_abort,
  output logic                           busy,
  output logic [clog2(NUM_REQ)-1:0]      grant_id,
  output logic                           timeout_err,
  input  logic                           err_clr
);

  localparam int IDX_W = clog2(NUM_REQ);
  localparam int GAP_W = clog2(GAP_CYCLES + 1);

  arb_state_t                 state_q, state_d;
  logic [WATCH_DOG_WIDTH-1:0] wd_q, wd_d;
  logic [GAP_W-1:0]           gap_q, gap_d;
  logic [IDX_W-1:0]           ptr_q, ptr_d;
  logic [IDX_W-1:0]           grant_q, grant_d;
  logic [FRAME_WIDTH-1:0]     frame_q, frame_d;
  logic [NUM_REQ-1:0]         ready_q, ready_d;
  logic [NUM_REQ-1:0]         done_q, done_d;
  logic                       shf_valid_q, shf_valid_d;
  logic                       abort_q, abort_d;
  logic                       err_q, err_d;
  logic                       busy_q, busy_d;
  logic                       err_set;

  logic                       pick_found;
  logic [IDX_W-1:0]           pick_idx;
  logic [FRAME_WIDTH-1:0]     frame_slot [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
    assign frame_slot[gi] = req_frame[gi*FRAME_WIDTH +: FRAME_WIDTH];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .valid (req_valid),
    .ptr   (ptr_q),
    .found (pick_found),
    .index (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    wd_d        = wd_q;
    gap_d       = gap_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    frame_d     = frame_q;
    shf_valid_d = shf_valid_q;
    ready_d     = '0;
    done_d      = '0;
    abort_d     = 1'b0;
    err_set     = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d           = pick_idx;
          frame_d           = frame_slot[pick_idx];
          ready_d[pick_idx] = 1'b1;
          shf_valid_d       = 1'b1;
          wd_d              = '0;
          state_d           = ISSUE;
        end
      end
      ISSUE: begin
        // An accepted handshake beats a watchdog expiry in the same cycle.
        if (shf_ready) begin
          shf_valid_d = 1'b0;
          wd_d        = '0;
          state_d     = WAIT;
        end else if (&wd_q) begin
          shf_valid_d = 1'b0;
          abort_d     = 1'b1;
          err_set     = 1'b1;
          gap_d       = '0;
          state_d     = GAP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      WAIT: begin
        if (shf_done) begin
          done_d[grant_q] = 1'b1;
          gap_d           = '0;
          state_d         = GAP;
        end else if (&wd_q) begin
          abort_d = 1'b1;
          err_set = 1'b1;
          gap_d   = '0;
          state_d = GAP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
          // Most recent owner drops to lowest priority for the next round.
          if (grant_q == IDX_W'(NUM_REQ - 1)) ptr_d = '0;
          else                                ptr_d = grant_q + 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (err_set)      err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
    else              err_d = err_q;

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state_q     <= IDLE;
      wd_q        <= '0;
      gap_q       <= '0;
      ptr_q       <= '0;
      grant_q     <= '0;
      frame_q     <= '0;
      ready_q     <= '0;
      done_q      <= '0;
      shf_valid_q <= 1'b0;
      abort_q     <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      gap_q       <= gap_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      frame_q     <= frame_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      shf_valid_q <= shf_valid_d;
      abort_q     <= abort_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready   = ready_q;
  assign req_done    = done_q;
  assign shf_valid   = shf_valid_q;
  assign shf_frame   = frame_q;
  assign shf_abort   = abort_q;
  assign busy        = busy_q;
  assign grant_id    = grant_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_dac_frame_arbiter.sv
// Randomized self-checking bench for dac_frame_arbiter against a plain
// round-robin / timing reference model.
`timescale 1ns/1ps
module tb_dac_frame_arbiter;
  import dac_pkg::*;

  localparam int N   = 3;
  localparam int FW  = 24;
  localparam int WD  = 12;
  localparam int GAP = 4;
  // Watchdog holds value v in the (v+1)-th WAIT cycle; abort is visible one
  // cycle after the cycle holding all-ones, counted from the handshake cycle.
  localparam int LAST_WD  = (1 << WD) - 1;
  localparam int ABORT_AT = LAST_WD + 2;

  logic            sys_clk = 1'b0;
  logic            sys_rst = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*FW-1:0] req_frame = '0;
  logic [N-1:0]    req_ready, req_done;
  logic            shf_valid, shf_abort, busy, timeout_err;
  logic [FW-1:0]   shf_frame;
  logic            shf_ready = 1'b0;
  logic            shf_done = 1'b0;
  logic            err_clr = 1'b0;
  logic [1:0]      grant_id;

  always #5 sys_clk = ~sys_clk;

  dac_frame_arbiter #(
    .NUM_REQ(N), .FRAME_WIDTH(FW), .WATCH_DOG_WIDTH(WD), .GAP_CYCLES(GAP)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .req_valid(req_valid), .req_frame(req_frame),
    .req_ready(req_ready), .req_done(req_done), .shf_valid(shf_valid), .shf_frame(shf_frame),
    .shf_ready(shf_ready), .shf_done(shf_done), .shf_abort(shf_abort), .busy(busy),
    .grant_id(grant_id), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  typedef struct {
    int            idx;
    logic [FW-1:0] frame;
    int            ready_lat;
    int            ready_pulses;
    int            done_idx;
    int            done_cnt;
    int            done_at;
    int            abort_cnt;
    int            abort_at;
    int            end_at;
    int            gap_len;
    bit            stable;
  } res_t;

  int checks = 0;
  int errors = 0;
  int m_ptr  = 0;
  logic [3:0] cmd_tab [5] = '{WR_INPUT, UPDATE, WR_UPDATE, RESET, READBACK};

  function automatic logic [FW-1:0] rand_frame();
    return {cmd_tab[$urandom_range(0, 4)], 4'($urandom_range(0, 15)), 16'($urandom)};
  endfunction

  function automatic int rr_expect(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic randomize_frames();
    for (int i = 0; i < N; i++) req_frame[i*FW +: FW] = rand_frame();
  endtask

  task automatic apply_reset();
    req_valid = '0; shf_ready = 0; shf_done = 0; err_clr = 0;
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b1;
    m_ptr = 0;
  endtask

  // Plays requester/shifter for one frame and records what the DUT did.
  task automatic serve_frame(input int rdy_dly, input int done_dly, input int clr_at,
                             input bit drop, output res_t r);
    int n;
    int t;
    r.idx = -1; r.frame = '0; r.ready_lat = -1; r.ready_pulses = 0; r.done_idx = -1;
    r.done_cnt = 0; r.done_at = -1; r.abort_cnt = 0; r.abort_at = -1; r.end_at = -1;
    r.gap_len = -1; r.stable = 1'b1;
    n = 0;
    do begin @(negedge sys_clk); n++; end while (req_ready == '0 && n < 20);
    r.ready_lat = n;
    if (req_ready == '0) return;
    r.ready_pulses = $countones(req_ready);
    for (int i = 0; i < N; i++) if (req_ready[i]) r.idx = i;
    r.frame  = shf_frame;
    r.stable = shf_valid;
    if (drop) req_valid[r.idx] = 1'b0;
    for (int k = 0; k < rdy_dly; k++) begin
      @(negedge sys_clk);
      r.ready_pulses += $countones(req_ready);
      if (!shf_valid || shf_frame !== r.frame) r.stable = 1'b0;
    end
    shf_ready = 1'b1;
    t = 0;
    while (t < 6000) begin
      @(negedge sys_clk);
      t++;
      shf_ready = 1'b0;
      if (t == 1 && shf_valid) r.stable = 1'b0;
      r.ready_pulses += $countones(req_ready);
      if (req_done != '0) begin
        r.done_cnt += $countones(req_done);
        r.done_at = t; r.end_at = t;
        for (int i = 0; i < N; i++) if (req_done[i]) r.done_idx = i;
      end
      if (shf_abort) begin r.abort_cnt++; r.abort_at = t; r.end_at = t; end
      if (!busy) begin
        if (r.end_at >= 0) r.gap_len = t - r.end_at;
        break;
      end
      shf_done = (done_dly >= 0 && t == done_dly + 1);
      err_clr  = (t == clr_at);
    end
    shf_done = 1'b0;
    err_clr  = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
    checks++; if (req_done !== '0) begin errors++; $display("FAIL reset_req_done got=%b exp=0", req_done); end
    checks++; if (shf_valid !== 1'b0) begin errors++; $display("FAIL reset_shf_valid got=%b exp=0", shf_valid); end
    checks++; if (shf_frame !== '0) begin errors++; $display("FAIL reset_shf_frame got=%h exp=0", shf_frame); end
    checks++; if (shf_abort !== 1'b0) begin errors++; $display("FAIL reset_shf_abort got=%b exp=0", shf_abort); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id got=%0d exp=0", grant_id); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err got=%b exp=0", timeout_err); end
    $display("reset: outputs sampled after reset");
  endtask

  task automatic test_single();
    res_t r;
    int   exp;
    randomize_frames();
    req_frame[1*FW +: FW] = 24'h318000;
    req_valid = 3'b010;
    exp = rr_expect(req_valid, m_ptr);
    serve_frame(3, 5, -1, 1'b1, r);
    m_ptr = (exp + 1) % N;
    $display("single: idx=%0d frame=%h done_at=%0d gap=%0d", r.idx, r.frame, r.done_at, r.gap_len);
    checks++; if (r.idx !== exp) begin errors++; $display("FAIL single_idx got=%0d exp=%0d", r.idx, exp); end
    checks++; if (r.ready_lat !== 1) begin errors++; $display("FAIL single_ready_latency got=%0d exp=1", r.ready_lat); end
    checks++; if (r.frame !== 24'h318000) begin errors++; $display("FAIL single_frame got=%h exp=318000", r.frame); end
    checks++; if (r.stable !== 1'b1) begin errors++; $display("FAIL single_hold got=%b exp=1", r.stable); end
    checks++; if (r.ready_pulses !== 1) begin errors++; $display("FAIL single_ready_pulses got=%0d exp=1", r.ready_pulses); end
    checks++; if (r.done_idx !== 1 || r.done_cnt !== 1) begin errors++; $display("FAIL single_done got=%0d/%0d exp=1/1", r.done_idx, r.done_cnt); end
    checks++; if (r.done_at !== 5 + 2) begin errors++; $display("FAIL single_done_latency got=%0d exp=%0d", r.done_at, 7); end
    checks++; if (r.gap_len !== GAP) begin errors++; $display("FAIL single_gap got=%0d exp=%0d", r.gap_len, GAP); end
    checks++; if (r.abort_cnt !== 0) begin errors++; $display("FAIL single_abort got=%0d exp=0", r.abort_cnt); end
  endtask

  task automatic test_round_robin();
    res_t          r;
    int            exp;
    logic [FW-1:0] exp_frame;
    apply_reset();
    req_valid = '1;
    for (int f = 0; f < 6; f++) begin
      randomize_frames();
      exp = rr_expect(req_valid, m_ptr);
      exp_frame = req_frame[exp*FW +: FW];
      serve_frame($urandom_range(0, 4), $urandom_range(0, 12), -1, 1'b0, r);
      m_ptr = (exp + 1) % N;
      $display("round_robin: frame %0d idx=%0d exp=%0d data=%h", f, r.idx, exp, r.frame);
      checks++; if (r.idx !== exp) begin errors++; $display("FAIL rr_order got=%0d exp=%0d", r.idx, exp); end
      checks++; if (r.frame !== exp_frame) begin errors++; $display("FAIL rr_frame got=%h exp=%h", r.frame, exp_frame); end
      checks++; if (r.ready_pulses !== 1) begin errors++; $display("FAIL rr_ready_pulses got=%0d exp=1", r.ready_pulses); end
      checks++; if (r.done_idx !== exp) begin errors++; $display("FAIL rr_done_owner got=%0d exp=%0d", r.done_idx, exp); end
    end
    req_valid = '0;
  endtask

  task automatic test_contention();
    res_t           r;
    int             exp;
    logic [N-1:0]   masks [3] = '{3'b100, 3'b101, 3'b100};
    for (int s = 0; s < 3; s++) begin
      randomize_frames();
      req_valid = req_valid | masks[s];
      exp = rr_expect(req_valid, m_ptr);
      serve_frame(1, $urandom_range(0, 8), -1, 1'b1, r);
      m_ptr = (exp + 1) % N;
      $display("contention: step %0d idx=%0d exp=%0d", s, r.idx, exp);
      checks++; if (r.idx !== exp) begin errors++; $display("FAIL contention_idx got=%0d exp=%0d", r.idx, exp); end
    end
    req_valid = '0;
  endtask

  task automatic test_random();
    res_t          r;
    int            exp;
    logic [FW-1:0] exp_frame;
    for (int f = 0; f < 8; f++) begin
      randomize_frames();
      req_valid = N'($urandom_range(1, (1 << N) - 1));
      exp = rr_expect(req_valid, m_ptr);
      exp_frame = req_frame[exp*FW +: FW];
      serve_frame($urandom_range(0, 5), $urandom_range(0, 20), -1, 1'b1, r);
      req_valid = '0;
      m_ptr = (exp + 1) % N;
      $display("random: frame %0d idx=%0d exp=%0d data=%h gap=%0d", f, r.idx, exp, r.frame, r.gap_len);
      checks++; if (r.idx !== exp || r.frame !== exp_frame) begin errors++; $display("FAIL random_grant got=%0d/%h exp=%0d/%h", r.idx, r.frame, exp, exp_frame); end
      checks++; if (r.gap_len !== GAP || r.done_cnt !== 1) begin errors++; $display("FAIL random_completion gap=%0d done=%0d exp=%0d/1", r.gap_len, r.done_cnt, GAP); end
    end
  endtask

  task automatic test_timeout();
    res_t r;
    int   exp;
    randomize_frames();
    req_valid = N'(1 << $urandom_range(0, N - 1));
    exp = rr_expect(req_valid, m_ptr);
    serve_frame(1, -1, -1, 1'b1, r);
    m_ptr = (exp + 1) % N;
    $display("timeout: idx=%0d abort_at=%0d done_cnt=%0d err=%b", r.idx, r.abort_at, r.done_cnt, timeout_err);
    checks++; if (r.abort_cnt !== 1 || r.abort_at !== ABORT_AT) begin errors++; $display("FAIL timeout_abort got=%0d@%0d exp=1@%0d", r.abort_cnt, r.abort_at, ABORT_AT); end
    checks++; if (r.done_cnt !== 0) begin errors++; $display("FAIL timeout_no_done got=%0d exp=0", r.done_cnt); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_err_set got=%b exp=1", timeout_err); end
    checks++; if (r.gap_len !== GAP) begin errors++; $display("FAIL timeout_gap got=%0d exp=%0d", r.gap_len, GAP); end
    randomize_frames();
    req_valid = N'($urandom_range(1, (1 << N) - 1));
    exp = rr_expect(req_valid, m_ptr);
    serve_frame(0, 3, -1, 1'b1, r);
    req_valid = '0;
    m_ptr = (exp + 1) % N;
    $display("timeout: follow-up idx=%0d exp=%0d err=%b", r.idx, exp, timeout_err);
    checks++; if (r.idx !== exp || r.done_cnt !== 1) begin errors++; $display("FAIL timeout_recover got=%0d/%0d exp=%0d/1", r.idx, r.done_cnt, exp); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_err_sticky got=%b exp=1", timeout_err); end
    err_clr = 1'b1;
    @(negedge sys_clk);
    err_clr = 1'b0;
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_err_clear got=%b exp=0", timeout_err); end
  endtask

  task automatic test_simultaneous();
    res_t r;
    int   exp;
    randomize_frames();
    req_valid = N'($urandom_range(1, (1 << N) - 1));
    exp = rr_expect(req_valid, m_ptr);
    serve_frame(0, LAST_WD, -1, 1'b1, r);
    req_valid = '0;
    m_ptr = (exp + 1) % N;
    $display("simultaneous: done vs expiry done_at=%0d abort=%0d err=%b", r.done_at, r.abort_cnt, timeout_err);
    checks++; if (r.done_cnt !== 1 || r.done_idx !== exp) begin errors++; $display("FAIL simul_done got=%0d/%0d exp=1/%0d", r.done_cnt, r.done_idx, exp); end
    checks++; if (r.abort_cnt !== 0) begin errors++; $display("FAIL simul_no_abort got=%0d exp=0", r.abort_cnt); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL simul_no_err got=%b exp=0", timeout_err); end
    randomize_frames();
    req_valid = N'($urandom_range(1, (1 << N) - 1));
    exp = rr_expect(req_valid, m_ptr);
    serve_frame(0, -1, ABORT_AT - 1, 1'b1, r);
    req_valid = '0;
    m_ptr = (exp + 1) % N;
    $display("simultaneous: clear vs set abort=%0d err=%b", r.abort_cnt, timeout_err);
    checks++; if (r.abort_cnt !== 1 || timeout_err !== 1'b1) begin errors++; $display("FAIL simul_set_wins got=%0d/%b exp=1/1", r.abort_cnt, timeout_err); end
    err_clr = 1'b1;
    @(negedge sys_clk);
    err_clr = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    res_t r;
    int   n;
    bit   quiet;
    randomize_frames();
    req_valid = 3'b001;
    serve_frame(0, 2, -1, 1'b1, r);
    m_ptr = 1;
    req_valid = 3'b010;
    n = 0;
    do begin @(negedge sys_clk); n++; end while (req_ready == '0 && n < 20);
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL rstmid_grant got=%b exp=010", req_ready); end
    req_valid = '0;
    shf_ready = 1'b1;
    @(negedge sys_clk);
    shf_ready = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    sys_rst = 1'b1;
    m_ptr = 0;
    $display("reset_mid_wait: outputs after reset busy=%b valid=%b", busy, shf_valid);
    checks++;
    if ({req_ready, req_done, shf_valid, shf_frame, shf_abort, busy, grant_id, timeout_err} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs got=%b/%b/%b/%h/%b/%b/%0d exp=all zero",
               req_ready, req_done, shf_valid, shf_frame, shf_abort, busy, grant_id);
    end
    quiet = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge sys_clk);
      if (req_done != '0 || shf_abort) quiet = 1'b0;
    end
    checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL rstmid_quiet got=%b exp=1", quiet); end
    randomize_frames();
    req_valid = '1;
    serve_frame(0, 1, -1, 1'b1, r);
    req_valid = '0;
    m_ptr = 1;
    $display("reset_mid_wait: first grant after reset idx=%0d", r.idx);
    checks++; if (r.idx !== 0) begin errors++; $display("FAIL rstmid_first_grant got=%0d exp=0", r.idx); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_contention();
    test_random();
    test_timeout();
    test_simultaneous();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
